// File: rtl/laplacian_edge_filter_if.sv
// -----------------------------------------------------------------------------
// laplacian_edge_filter_if
//
// Pixel stream bundle for the Laplacian edge filter.
//   in_valid     : in_data carries a pixel this cycle (gaps of any length)
//   in_sof       : qualified by in_valid, this pixel is (x=0, y=0)
//   in_data      : RGB444 pixel, R=[11:8], G=[7:4], B=[3:0]
//   out_valid    : out_base/out_filtered valid this cycle
//   out_sof      : output belongs to the in_sof input pixel
//   out_base     : centre pixel of the 3x3 window
//   out_filtered : per-channel clamped Laplacian magnitude
//
// Modports:
//   master : video source side (drives in_*, observes out_*)
//   slave  : filter side (consumes in_*, drives out_*)
// -----------------------------------------------------------------------------
interface laplacian_edge_filter_if;
   logic        in_valid;
   logic        in_sof;
   logic [11:0] in_data;
   logic        out_valid;
   logic        out_sof;
   logic [11:0] out_base;
   logic [11:0] out_filtered;

   modport master (
      output in_valid, in_sof, in_data,
      input  out_valid, out_sof, out_base, out_filtered
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output out_valid, out_sof, out_base, out_filtered
   );
endinterface

// File: rtl/laplacian_edge_filter.sv
// -----------------------------------------------------------------------------
// laplacian_edge_filter
//
// Streaming 3x3 Laplacian high-pass stage for RGB444 video. For every input
// pixel it emits, exactly 3 cycles later, the window centre pixel (base) and a
// per-channel clamped edge magnitude L = 4*C - N - S - E - W (filtered).
// Pixels whose input position has x<2 or y<2 produce 000/000 with out_valid
// still asserted, so the output image is the input shifted one pixel
// right/down with a two-pixel black band at the top and left.
//
// Parameters:
//   H_RES : active pixels per line
//   V_RES : active lines per frame
//
// Ports:
//   clk   : pixel clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : laplacian_edge_filter_if.slave (input and output pixel streams)
//
// Pipeline (one register stage each, runs every cycle):
//   s1  : position counters, line-buffer reads/writes, input pixel capture
//   s2  : 3x3 window shift (only when s1 holds a valid pixel)
//   out : Laplacian + clamp, border blanking, output registers
// -----------------------------------------------------------------------------
module laplacian_edge_filter #(
   parameter int H_RES = 320,
   parameter int V_RES = 240
) (
   input  logic                    clk,
   input  logic                    reset,
   laplacian_edge_filter_if.slave  bus
);

   localparam int XW = (H_RES > 3) ? $clog2(H_RES) : 2;
   localparam int YW = (V_RES > 3) ? $clog2(V_RES) : 2;

   // ------------------------------------------------------------------
   // Position counters
   // ------------------------------------------------------------------
   logic [XW-1:0] x_reg;
   logic [YW-1:0] y_reg;
   logic [XW-1:0] x_cur;
   logic [YW-1:0] y_cur;
   logic [XW-1:0] x_next;
   logic [YW-1:0] y_next;

   // Position of the pixel on the bus this cycle; in_sof overrides the
   // running counters so a mid-frame sof restarts the frame at once.
   always_comb begin
      x_cur  = bus.in_sof ? '0 : x_reg;
      y_cur  = bus.in_sof ? '0 : y_reg;
      x_next = x_cur + XW'(1);
      y_next = y_cur;
      if (x_cur == XW'(H_RES - 1)) begin
         x_next = '0;
         y_next = (y_cur == YW'(V_RES - 1)) ? '0 : y_cur + YW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Stage-1 registers
   // ------------------------------------------------------------------
   logic          s1_valid_reg;
   logic          s1_sof_reg;
   logic          s1_border_reg;
   logic [XW-1:0] s1_x_reg;
   logic [11:0]   s1_data_reg;

   // Line buffers: lb1 holds row y-1, lb2 holds row y-2 (per column).
   logic [11:0]   lb1_mem [0:H_RES-1];
   logic [11:0]   lb2_mem [0:H_RES-1];
   logic [11:0]   lb1_rd_reg;
   logic [11:0]   lb2_rd_reg;

   // lb2 is written one cycle late (with the registered lb1 read data). If
   // the next pixel reads the same column that is being written that cycle
   // (only possible when two consecutive pixels share a column, e.g. two
   // back-to-back sof pixels), the in-flight word is forwarded instead.
   logic          fwd_reg;
   logic [11:0]   fwd_data_reg;
   logic [11:0]   lb2_word;

   assign lb2_word = fwd_reg ? fwd_data_reg : lb2_rd_reg;

   // Block-RAM style storage: registered reads, no reset on contents.
   always_ff @(posedge clk) begin
      if (!reset && bus.in_valid) begin
         lb1_mem[x_cur] <= bus.in_data;
         lb1_rd_reg     <= lb1_mem[x_cur];
         lb2_rd_reg     <= lb2_mem[x_cur];
      end
      if (!reset && s1_valid_reg) begin
         lb2_mem[s1_x_reg] <= lb1_rd_reg;
      end
   end

   // ------------------------------------------------------------------
   // Window. Only the five taps of the 4-neighbour kernel are kept:
   //   top row    (y-2): columns x-1, x
   //   middle row (y-1): columns x-2, x-1, x
   //   bottom row (y)  : columns x-1, x
   // Index 2 is the newest column (x); the centre is mid_reg[1].
   // ------------------------------------------------------------------
   logic [2:1][11:0] top_reg;
   logic [2:0][11:0] mid_reg;
   logic [2:1][11:0] bot_reg;

   logic             s2_valid_reg;
   logic             s2_sof_reg;
   logic             s2_border_reg;

   // ------------------------------------------------------------------
   // Per-channel Laplacian and clamp
   // ------------------------------------------------------------------
   logic [11:0] filt_calc;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [3:0]        c_pix;
         logic [3:0]        n_pix;
         logic [3:0]        s_pix;
         logic [3:0]        w_pix;
         logic [3:0]        e_pix;
         logic signed [7:0] lap;

         assign c_pix = mid_reg[1][gi*4 +: 4];
         assign n_pix = top_reg[1][gi*4 +: 4];
         assign s_pix = bot_reg[1][gi*4 +: 4];
         assign w_pix = mid_reg[0][gi*4 +: 4];
         assign e_pix = mid_reg[2][gi*4 +: 4];

         // Range is -60..+60, so 8 signed bits never overflow.
         assign lap = $signed({2'b00, c_pix, 2'b00})
                    - $signed({4'b0000, n_pix})
                    - $signed({4'b0000, s_pix})
                    - $signed({4'b0000, w_pix})
                    - $signed({4'b0000, e_pix});

         assign filt_calc[gi*4 +: 4] = lap[7]         ? 4'd0  :
                                       (lap > 8'sd15) ? 4'd15 : lap[3:0];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   logic        out_valid_reg;
   logic        out_sof_reg;
   logic [11:0] out_base_reg;
   logic [11:0] out_filtered_reg;

   assign bus.out_valid    = out_valid_reg;
   assign bus.out_sof      = out_sof_reg;
   assign bus.out_base     = out_base_reg;
   assign bus.out_filtered = out_filtered_reg;

   // ------------------------------------------------------------------
   // Control and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         x_reg            <= '0;
         y_reg            <= '0;
         s1_valid_reg     <= 1'b0;
         s1_sof_reg       <= 1'b0;
         s1_border_reg    <= 1'b0;
         s1_x_reg         <= '0;
         s1_data_reg      <= '0;
         fwd_reg          <= 1'b0;
         fwd_data_reg     <= '0;
         top_reg          <= '0;
         mid_reg          <= '0;
         bot_reg          <= '0;
         s2_valid_reg     <= 1'b0;
         s2_sof_reg       <= 1'b0;
         s2_border_reg    <= 1'b0;
         out_valid_reg    <= 1'b0;
         out_sof_reg      <= 1'b0;
         out_base_reg     <= '0;
         out_filtered_reg <= '0;
      end else begin
         // Stage 1: counters and input capture.
         s1_valid_reg <= bus.in_valid;
         s1_sof_reg   <= bus.in_valid & bus.in_sof;
         if (bus.in_valid) begin
            x_reg         <= x_next;
            y_reg         <= y_next;
            s1_x_reg      <= x_cur;
            s1_data_reg   <= bus.in_data;
            s1_border_reg <= (x_cur < XW'(2)) || (y_cur < YW'(2));
            fwd_reg       <= s1_valid_reg && (s1_x_reg == x_cur);
            fwd_data_reg  <= lb1_rd_reg;
         end

         // Stage 2: shift the window left by one column.
         s2_valid_reg  <= s1_valid_reg;
         s2_sof_reg    <= s1_sof_reg;
         s2_border_reg <= s1_border_reg;
         if (s1_valid_reg) begin
            top_reg[1] <= top_reg[2];
            top_reg[2] <= lb2_word;
            mid_reg[0] <= mid_reg[1];
            mid_reg[1] <= mid_reg[2];
            mid_reg[2] <= lb1_rd_reg;
            bot_reg[1] <= bot_reg[2];
            bot_reg[2] <= s1_data_reg;
         end

         // Stage 3: border blanking and output. Border pixels hide any
         // stale or uninitialised line-buffer data.
         out_valid_reg <= s2_valid_reg;
         out_sof_reg   <= s2_valid_reg & s2_sof_reg;
         if (s2_valid_reg && !s2_border_reg) begin
            out_base_reg     <= mid_reg[1];
            out_filtered_reg <= filt_calc;
         end else begin
            out_base_reg     <= '0;
            out_filtered_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_laplacian_edge_filter.sv
// -----------------------------------------------------------------------------
// tb_laplacian_edge_filter
//
// Self-checking bench for laplacian_edge_filter on a reduced 40x36 raster.
// Every driven pixel pushes its expected output (computed from an image
// model of the most recent pixel at each position) onto a queue; outputs are
// popped and compared when out_valid appears, including the exact 3-cycle
// arrival time. A table of frame/probe vectors adds hand-computed checks, and
// hand-written sequences cover reset mid-frame, mid-line sof and wrap-around
// between frames without sof.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_laplacian_edge_filter;
   localparam int H = 40;
   localparam int V = 36;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   laplacian_edge_filter_if bus ();

   laplacian_edge_filter #(.H_RES(H), .V_RES(V)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;

   // ------------------------------------------------------------------
   // Model and scoreboard
   // ------------------------------------------------------------------
   typedef struct {
      int          x;
      int          y;
      logic        sof;
      logic [11:0] base;
      logic [11:0] filt;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   exp_t        chk_e;
   logic [11:0] img      [0:V-1][0:H-1];
   logic [11:0] cap_base [0:V-1][0:H-1];
   logic [11:0] cap_filt [0:V-1][0:H-1];
   int          mx = 0;
   int          my = 0;

   function automatic logic [11:0] lap_model(input int x, input int y);
      logic [11:0] r;
      logic [11:0] pc, pn, ps, pw, pe;
      int          l;
      r  = 12'h000;
      pc = img[y-1][x-1];
      pn = img[y-2][x-1];
      ps = img[y][x-1];
      pw = img[y-1][x-2];
      pe = img[y-1][x];
      for (int ch = 0; ch < 3; ch++) begin
         l = 4 * int'(pc[ch*4 +: 4]) - int'(pn[ch*4 +: 4]) - int'(ps[ch*4 +: 4])
           - int'(pw[ch*4 +: 4]) - int'(pe[ch*4 +: 4]);
         if (l < 0)  l = 0;
         if (l > 15) l = 15;
         r[ch*4 +: 4] = l[3:0];
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic sof, input logic [11:0] d);
      exp_t e;
      @(posedge clk); #1;
      bus.in_valid = v;
      bus.in_sof   = sof;
      bus.in_data  = d;
      if (v) begin
         if (sof) begin
            mx = 0;
            my = 0;
         end
         img[my][mx] = d;
         e.x   = mx;
         e.y   = my;
         e.sof = sof;
         e.due = cyc + 3;
         if (mx < 2 || my < 2) begin
            e.base = 12'h000;
            e.filt = 12'h000;
         end else begin
            e.base = img[my-1][mx-1];
            e.filt = lap_model(mx, my);
         end
         sbq.push_back(e);
         if (mx == H - 1) begin
            mx = 0;
            my = (my == V - 1) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
      end
   endtask

   // Output checker: one scoreboard comparison per output pixel.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         n_tests = n_tests + 1;
         if (sbq.size() == 0) begin
            n_fail = n_fail + 1;
            if (n_print < 20) $display("FAIL unexpected_out: got out_valid=1 at cyc %0d, required none", cyc);
            n_print = n_print + 1;
         end else begin
            chk_e = sbq.pop_front();
            cap_base[chk_e.y][chk_e.x] = bus.out_base;
            cap_filt[chk_e.y][chk_e.x] = bus.out_filtered;
            if (bus.out_base !== chk_e.base || bus.out_filtered !== chk_e.filt ||
                bus.out_sof !== chk_e.sof || cyc != chk_e.due) begin
               n_fail = n_fail + 1;
               if (n_print < 20)
                  $display("FAIL pixel(%0d,%0d): got base=%03h filt=%03h sof=%0b cyc=%0d, required base=%03h filt=%03h sof=%0b cyc=%0d",
                           chk_e.x, chk_e.y, bus.out_base, bus.out_filtered, bus.out_sof, cyc,
                           chk_e.base, chk_e.filt, chk_e.sof, chk_e.due);
               n_print = n_print + 1;
            end
         end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
         n_tests = n_tests + 1;
         n_fail  = n_fail + 1;
         if (n_print < 20)
            $display("FAIL missing_out: pixel(%0d,%0d) got out_valid=0 at cyc %0d, required 1 at cyc %0d",
                     sbq[0].x, sbq[0].y, cyc, sbq[0].due);
         n_print = n_print + 1;
         void'(sbq.pop_front());
      end
   end

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic check12(input string name, input logic [11:0] act, input logic [11:0] req);
      n_tests = n_tests + 1;
      if (act !== req) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %03h, required %03h", name, act, req);
      end else begin
         $display("[TB] %s = %03h ok", name, act);
      end
   endtask

   task automatic clear_caps();
      for (int yy = 0; yy < V; yy++)
         for (int xx = 0; xx < H; xx++) begin
            cap_base[yy][xx] = 12'hBAD;
            cap_filt[yy][xx] = 12'hBAD;
         end
   endtask

   // Sends npix pixels of a frame: background bg with value sv at (sx,sy).
   task automatic send_frame(input logic [11:0] bg, input int sx, input int sy,
                             input logic [11:0] sv, input logic with_sof,
                             input int gap, input int npix);
      int          px, py;
      logic [11:0] p;
      for (int i = 0; i < npix; i++) begin
         px = i % H;
         py = i / H;
         p  = (px == sx && py == sy) ? sv : bg;
         if (gap > 0)
            while ($urandom_range(0, 99) < gap) drive(1'b0, 1'b0, 12'h000);
         drive(1'b1, with_sof && (i == 0), p);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      drive(1'b0, 1'b0, 12'h000);
      while (sbq.size() != 0 && k < 20) begin
         @(negedge clk);
         k = k + 1;
      end
      if (sbq.size() != 0) begin
         n_tests = n_tests + 1;
         n_fail  = n_fail + 1;
         $display("FAIL drain: got %0d outputs outstanding, required 0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic probe(input string tag, input int x, input int y,
                        input logic [11:0] eb, input logic [11:0] ef);
      check12($sformatf("%s base(%0d,%0d)", tag, x, y), cap_base[y][x], eb);
      check12($sformatf("%s filt(%0d,%0d)", tag, x, y), cap_filt[y][x], ef);
   endtask

   // ------------------------------------------------------------------
   // Vector table: frame content plus one probe at an input position
   // ------------------------------------------------------------------
   typedef struct {
      logic [11:0] bg;
      int          sx;
      int          sy;
      logic [11:0] sv;
      int          gap;
      int          px;
      int          py;
      logic [11:0] eb;
      logic [11:0] ef;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [0:NV-1];

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish by cyc %0d, required finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      // flat grey
      vecs[0]  = '{12'h888, -1, -1, 12'h888,  0,  5,  5, 12'h888, 12'h000};
      vecs[1]  = '{12'h888, -1, -1, 12'h888,  0,  1,  5, 12'h000, 12'h000};
      vecs[2]  = '{12'h888, -1, -1, 12'h888,  0, 39, 35, 12'h888, 12'h000};
      // bright impulse at (10,10)
      vecs[3]  = '{12'h000, 10, 10, 12'hFFF,  0, 11, 11, 12'hFFF, 12'hFFF};
      vecs[4]  = '{12'h000, 10, 10, 12'hFFF,  0, 10, 11, 12'h000, 12'h000};
      vecs[5]  = '{12'h000, 10, 10, 12'hFFF,  0, 12, 11, 12'h000, 12'h000};
      vecs[6]  = '{12'h000, 10, 10, 12'hFFF,  0, 11, 10, 12'h000, 12'h000};
      vecs[7]  = '{12'h000, 10, 10, 12'hFFF,  0, 11, 12, 12'h000, 12'h000};
      // channel independence
      vecs[8]  = '{12'h000, 20, 20, 12'h1F0,  0, 21, 21, 12'h1F0, 12'h4F0};
      // dark pixel on grey
      vecs[9]  = '{12'h444, 30, 30, 12'h000,  0, 31, 31, 12'h000, 12'h000};
      vecs[10] = '{12'h444, 30, 30, 12'h000,  0, 32, 31, 12'h444, 12'h444};
      vecs[11] = '{12'h444, 30, 30, 12'h000,  0, 31, 30, 12'h444, 12'h444};
      // gapped input at 50% duty
      vecs[12] = '{12'h000, 10, 10, 12'hFFF, 50, 11, 11, 12'hFFF, 12'hFFF};
      vecs[13] = '{12'h000, 20, 20, 12'h1F0, 50, 21, 21, 12'h1F0, 12'h4F0};

      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = 12'h000;
      reset        = 1'b1;
      for (int yy = 0; yy < V; yy++)
         for (int xx = 0; xx < H; xx++) img[yy][xx] = 12'h000;

      // Reset state, with in_valid held high during reset (must be ignored).
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b1;
      bus.in_data  = 12'h123;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check12("reset out_valid",    {11'd0, bus.out_valid}, 12'h000);
      check12("reset out_sof",      {11'd0, bus.out_sof},   12'h000);
      check12("reset out_base",     bus.out_base,           12'h000);
      check12("reset out_filtered", bus.out_filtered,       12'h000);
      @(posedge clk); #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      repeat (4) @(negedge clk);

      // Table-driven frames
      for (int i = 0; i < NV; i++) begin
         clear_caps();
         send_frame(vecs[i].bg, vecs[i].sx, vecs[i].sy, vecs[i].sv, 1'b1, vecs[i].gap, H * V);
         drain();
         probe($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].eb, vecs[i].ef);
      end

      // Back-to-back frames; the second wraps to (0,0) without in_sof.
      clear_caps();
      send_frame(12'h888, -1, -1, 12'h888, 1'b1, 0, H * V);
      send_frame(12'h000, 10, 10, 12'hFFF, 1'b0, 0, H * V);
      drain();
      probe("wrap", 11, 11, 12'hFFF, 12'hFFF);
      probe("wrap", 5, 5, 12'h000, 12'h000);

      // Reset for one cycle in the middle of a frame (in_valid also high).
      send_frame(12'h000, 10, 10, 12'hFFF, 1'b1, 0, 500);
      @(posedge clk); #1;
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b0;
      bus.in_data  = 12'hABC;
      @(posedge clk); #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      sbq.delete();
      mx = 0;
      my = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check12($sformatf("post-reset out_valid %0d", k), {11'd0, bus.out_valid}, 12'h000);
      end
      clear_caps();
      send_frame(12'h000, 10, 10, 12'hFFF, 1'b1, 0, H * V);
      drain();
      probe("resync", 11, 11, 12'hFFF, 12'hFFF);

      // in_sof mid-line at x=20 of row 5 restarts the frame there.
      send_frame(12'h888, -1, -1, 12'h888, 1'b1, 0, H * 5 + 20);
      clear_caps();
      send_frame(12'h000, 10, 10, 12'hFFF, 1'b1, 0, H * V);
      drain();
      probe("midsof", 25, 1, 12'h000, 12'h000);
      probe("midsof", 11, 11, 12'hFFF, 12'hFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
